status_flag_unit: RTL and testbench

- Architectural NZCV status register that sits directly upstream of the ID-stage condition checker and supplies its 4-bit status input.
- Latches flag results from the EXE stage under a per-flag write mask.
- Scoreboards flag-setting instructions between ID issue and EXE write-back.
- Raises a hazard so that a conditional instruction in ID never evaluates stale flags.

---
 rtl/status_flag_unit.sv | 123 ++++++++++++
 tb/tb_status_flag_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/status_flag_unit.sv
// -----------------------------------------------------------------------------
// status_flag_unit
//   Architectural NZCV status register feeding the ID-stage condition checker.
//   Flag results from EXE are latched under a per-flag write mask. A small
//   scoreboard counts flag-setting instructions between ID issue and EXE
//   commit, so a conditional instruction in ID is stalled rather than
//   evaluating stale flags.
//
//   Optional feature macro: FLAG_BYPASS_EN
//     When defined, the flags being committed in EXE are forwarded to
//     status_out in the same cycle, and the final committing instruction no
//     longer stalls ID. Registered state is identical in both builds.
//
// Parameters:
//   MAX_PENDING : maximum flag-setting instructions in flight (default 3)
//   CNT_W       : pending-counter width, 2**CNT_W > MAX_PENDING (default 2)
//
// Ports:
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   freeze        in   global pipeline freeze, all state holds
//   flush         in   branch-taken flush of younger instructions
//   id_s_issue    in   S-bit instruction leaves ID this cycle
//   id_cond_used  in   instruction in ID is conditional
//   exe_s_en      in   instruction in EXE writes flags this cycle
//   exe_status_in in   ALU flags {N,Z,C,V}
//   exe_flag_mask in   per-flag write enables {N,Z,C,V}
//   status_out    out  NZCV to condition checker ([3]=N [2]=Z [1]=C [0]=V)
//   flags_hazard  out  stall request to ID / hazard unit
//   pending_cnt   out  current scoreboard count
//   sb_error      out  sticky scoreboard overflow/underflow error
// -----------------------------------------------------------------------------
module status_flag_unit #(
  parameter int MAX_PENDING = 3,
  parameter int CNT_W       = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             freeze,
  input  logic             flush,
  input  logic             id_s_issue,
  input  logic             id_cond_used,
  input  logic             exe_s_en,
  input  logic [3:0]       exe_status_in,
  input  logic [3:0]       exe_flag_mask,
  output logic [3:0]       status_out,
  output logic             flags_hazard,
  output logic [CNT_W-1:0] pending_cnt,
  output logic             sb_error
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PENDING);

  logic [3:0]       status_q, status_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [3:0]       merged;
  logic             inc, dec;

  // Masked merge of the EXE flags over the architectural register.
  assign merged = (exe_flag_mask & exe_status_in) | (~exe_flag_mask & status_q);

  // A flushed issue is killed, so it never enters the scoreboard.
  assign inc = id_s_issue & ~flush;
  assign dec = exe_s_en;

  always_comb begin
    status_d = status_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    if (!freeze) begin
      // A zero mask still counts as a commit; only the register is untouched.
      if (exe_s_en) begin
        status_d = merged;
      end
      // Flush wins: a same-cycle commit belongs to an older instruction and
      // every younger issued S instruction is gone.
      if (flush) begin
        cnt_d = '0;
      end else if (inc && !dec) begin
        if (cnt_q == MAX_CNT) begin
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else if (dec && !inc) begin
        if (cnt_q == '0) begin
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= 4'b0000;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      status_q <= status_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign pending_cnt = cnt_q;
  assign sb_error    = err_q;

`ifdef FLAG_BYPASS_EN
  logic [CNT_W-1:0] cnt_after_commit;

  assign status_out       = (exe_s_en && !freeze) ? merged : status_q;
  assign cnt_after_commit = cnt_q - CNT_W'(exe_s_en);
  // Gated by rst_n: the wrapped subtraction at count 0 must not stall during reset.
  assign flags_hazard     = rst_n & id_cond_used & (cnt_after_commit != '0);
`else
  assign status_out   = status_q;
  assign flags_hazard = rst_n & id_cond_used & (cnt_q != '0);
`endif

endmodule

// File: tb/tb_status_flag_unit.sv
// -----------------------------------------------------------------------------
// tb_status_flag_unit
//   Directed scoreboard bench for status_flag_unit. Each stimulus step pushes
//   the hand-computed outputs expected during that cycle; a monitor pops and
//   compares at the falling edge.
// -----------------------------------------------------------------------------
module tb_status_flag_unit;

  logic       clk;
  logic       rst_n;
  logic       freeze;
  logic       flush;
  logic       id_s_issue;
  logic       id_cond_used;
  logic       exe_s_en;
  logic [3:0] exe_status_in;
  logic [3:0] exe_flag_mask;
  logic [3:0] status_out;
  logic       flags_hazard;
  logic [1:0] pending_cnt;
  logic       sb_error;

  typedef struct {
    string      name;
    logic [3:0] st;
    logic [1:0] cnt;
    logic       err;
    logic       haz;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  status_flag_unit #(.MAX_PENDING(3), .CNT_W(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .freeze       (freeze),
    .flush        (flush),
    .id_s_issue   (id_s_issue),
    .id_cond_used (id_cond_used),
    .exe_s_en     (exe_s_en),
    .exe_status_in(exe_status_in),
    .exe_flag_mask(exe_flag_mask),
    .status_out   (status_out),
    .flags_hazard (flags_hazard),
    .pending_cnt  (pending_cnt),
    .sb_error     (sb_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare whatever the DUT presents against the queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (status_out !== e.st) begin
        errors++;
        $display("FAIL %s status_out: got %b expected %b", e.name, status_out, e.st);
      end
      checks++;
      if (pending_cnt !== e.cnt) begin
        errors++;
        $display("FAIL %s pending_cnt: got %0d expected %0d", e.name, pending_cnt, e.cnt);
      end
      checks++;
      if (sb_error !== e.err) begin
        errors++;
        $display("FAIL %s sb_error: got %b expected %b", e.name, sb_error, e.err);
      end
      checks++;
      if (flags_hazard !== e.haz) begin
        errors++;
        $display("FAIL %s flags_hazard: got %b expected %b", e.name, flags_hazard, e.haz);
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected during it.
  // st/haz are for the registered build, st_b/haz_b for the bypass build.
  task automatic step(input string nm,
                      input logic fz, input logic fl, input logic iss,
                      input logic cu, input logic sen,
                      input logic [3:0] stat, input logic [3:0] mask,
                      input logic [3:0] st, input logic [3:0] st_b,
                      input logic [1:0] cnt, input logic err,
                      input logic haz, input logic haz_b);
    exp_t e;
    freeze        = fz;
    flush         = fl;
    id_s_issue    = iss;
    id_cond_used  = cu;
    exe_s_en      = sen;
    exe_status_in = stat;
    exe_flag_mask = mask;
    e.name = nm;
    e.cnt  = cnt;
    e.err  = err;
`ifdef FLAG_BYPASS_EN
    e.st  = st_b;
    e.haz = haz_b;
`else
    e.st  = st;
    e.haz = haz;
`endif
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    rst_n = 1'b0;
    freeze = 0; flush = 0; id_s_issue = 0; id_cond_used = 0;
    exe_s_en = 0; exe_status_in = 4'h0; exe_flag_mask = 4'h0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    //    name         fz fl is cu se stat     mask     st       st_b     cnt  err h  h_b
    step("rst_state",  0, 0, 0, 1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0, 0);
    step("issue_c0",   0, 0, 1, 1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0, 0);
    step("haz_c1",     0, 0, 0, 1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd1, 0, 1, 1);
    step("commit_c2",  0, 0, 0, 1, 1, 4'b1111, 4'b1111, 4'b0000, 4'b1111, 2'd1, 0, 1, 0);
    step("clear_c3",   0, 0, 0, 1, 0, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 2'd0, 0, 0, 0);
    step("iss_mask",   0, 0, 1, 0, 0, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 2'd0, 0, 0, 0);
    step("mask_wr",    0, 0, 0, 0, 1, 4'b0000, 4'b1100, 4'b1111, 4'b0011, 2'd1, 0, 0, 0);
    step("mask_res",   0, 0, 0, 1, 0, 4'b0000, 4'b0000, 4'b0011, 4'b0011, 2'd0, 0, 0, 0);
    step("iss_sim",    0, 0, 1, 0, 0, 4'b0000, 4'b0000, 4'b0011, 4'b0011, 2'd0, 0, 0, 0);
    step("sim_incdec", 0, 0, 1, 1, 1, 4'b1010, 4'b1111, 4'b0011, 4'b1010, 2'd1, 0, 1, 0);
    step("sim_hold",   0, 0, 1, 1, 0, 4'b0000, 4'b0000, 4'b1010, 4'b1010, 2'd1, 0, 1, 1);
    step("flush_all",  0, 1, 1, 1, 1, 4'b0101, 4'b0011, 4'b1010, 4'b1001, 2'd2, 0, 1, 1);
    step("flush_res",  0, 0, 0, 1, 0, 4'b0000, 4'b0000, 4'b1001, 4'b1001, 2'd0, 0, 0, 0);
    step("iss_frz",    0, 0, 1, 0, 0, 4'b0000, 4'b0000, 4'b1001, 4'b1001, 2'd0, 0, 0, 0);
    step("freeze",     1, 1, 1, 1, 1, 4'b0110, 4'b1111, 4'b1001, 4'b1001, 2'd1, 0, 1, 0);
    step("frz_hold",   0, 0, 0, 1, 0, 4'b0000, 4'b0000, 4'b1001, 4'b1001, 2'd1, 0, 1, 1);
    step("ovf_iss2",   0, 0, 1, 0, 0, 4'b0000, 4'b0000, 4'b1001, 4'b1001, 2'd1, 0, 0, 0);
    step("ovf_iss3",   0, 0, 1, 0, 0, 4'b0000, 4'b0000, 4'b1001, 4'b1001, 2'd2, 0, 0, 0);
    step("ovf_iss4",   0, 0, 1, 0, 0, 4'b0000, 4'b0000, 4'b1001, 4'b1001, 2'd3, 0, 0, 0);
    step("ovf_res",    0, 0, 0, 1, 0, 4'b0000, 4'b0000, 4'b1001, 4'b1001, 2'd3, 1, 1, 1);

    // Asynchronous reset asserted mid-cycle; checked before any clock edge.
    freeze = 0; flush = 0; id_s_issue = 0; id_cond_used = 1;
    exe_s_en = 0; exe_status_in = 4'h0; exe_flag_mask = 4'h0;
    #1 rst_n = 1'b0;
    e.name = "async_rst"; e.st = 4'b0000; e.cnt = 2'd0; e.err = 1'b0; e.haz = 1'b0;
    exp_q.push_back(e);
    @(posedge clk);
    #1 rst_n = 1'b1;

    step("udf_dec",    0, 0, 0, 0, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0, 0);
    step("udf_res",    0, 0, 0, 1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1, 0, 0);

    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
